// File: rtl/axrm_error_monitor_if.sv
// Sample/report bundle between an approximate-multiplier tap and its error monitor.
// master = sample producer / report consumer, slave = the monitor itself.
interface axrm_error_monitor_if #(
  parameter int WIN_LOG2 = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              a;
  logic [7:0]              b;
  logic [15:0]             result;
  logic                    rpt_valid;
  logic                    rpt_ready;
  logic [16+WIN_LOG2-1:0]  rpt_sum_ed;
  logic [WIN_LOG2:0]       rpt_err_cnt;
  logic [15:0]             rpt_max_ed;

  modport master (
    output in_valid, a, b, result, rpt_ready,
    input  in_ready, rpt_valid, rpt_sum_ed, rpt_err_cnt, rpt_max_ed
  );

  modport slave (
    input  in_valid, a, b, result, rpt_ready,
    output in_ready, rpt_valid, rpt_sum_ed, rpt_err_cnt, rpt_max_ed
  );
endinterface

// File: rtl/axrm_error_monitor.sv
// Windowed error-distance statistics for an 8x8 approximate multiplier; report 1 cycle after last sample, held until rpt_ready.
// Samples stall (in_ready=0) while flushing/reporting. Max-ED tracker built only with AXRM_ERROR_MONITOR_MAX_ED_EN.
module axrm_error_monitor #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  axrm_error_monitor_if.slave  mon
);
  localparam int SW = 16 + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_ONE = 1;
  localparam logic [WIN_LOG2:0]   ERR_ONE = 1;

  typedef enum logic [1:0] {ACCUM, FLUSH, REPORT} state_t;

  state_t              state_q, state_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic                pv_q, pv_d;
  logic [15:0]         ed_q, ed_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic [WIN_LOG2:0]   err_q, err_d;

  logic        in_ready_o, rpt_valid_o;
  logic        accept, last_sample, rpt_take;
  logic [15:0] prod;
  logic [16:0] diff;
  logic [15:0] ed;

  // Exact reference product and |exact - approx|; the 17-bit difference never overflows.
  always_comb begin
    prod = {8'd0, mon.a} * {8'd0, mon.b};
    diff = {1'b0, prod} - {1'b0, mon.result};
    ed   = diff[16] ? (~diff[15:0] + 16'd1) : diff[15:0];
  end

  always_comb begin
    accept      = mon.in_valid & in_ready_o & ~clear;
    last_sample = accept & (cnt_q == '1);
    rpt_take    = rpt_valid_o & mon.rpt_ready;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last_sample) state_d = FLUSH;
        FLUSH:   state_d = REPORT;
        REPORT:  if (rpt_take) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready_o  = (state_q == ACCUM);
    rpt_valid_o = (state_q == REPORT);
  end

  // FLUSH exists so the last sample's ED, still in the pipeline stage, lands before REPORT.
  always_comb begin
    cnt_d = cnt_q;
    pv_d  = accept;
    ed_d  = accept ? ed : ed_q;
    sum_d = sum_q;
    err_d = err_q;
    if (accept) cnt_d = cnt_q + CNT_ONE;
    if (pv_q) begin
      sum_d = sum_q + {{WIN_LOG2{1'b0}}, ed_q};
      if (ed_q != 16'd0) err_d = err_q + ERR_ONE;
    end
    if (rpt_take) begin
      sum_d = '0;
      err_d = '0;
    end
    if (clear) begin
      cnt_d = '0;
      pv_d  = 1'b0;
      sum_d = '0;
      err_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pv_q  <= 1'b0;
      ed_q  <= '0;
      sum_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
      ed_q  <= ed_d;
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

`ifdef AXRM_ERROR_MONITOR_MAX_ED_EN
  logic [15:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (pv_q && (ed_q > max_q)) max_d = ed_q;
    if (rpt_take || clear)      max_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_q <= '0;
    else        max_q <= max_d;
  end

  assign mon.rpt_max_ed = max_q;
`else
  assign mon.rpt_max_ed = 16'd0;
`endif

  assign mon.in_ready    = in_ready_o;
  assign mon.rpt_valid   = rpt_valid_o;
  assign mon.rpt_sum_ed  = sum_q;
  assign mon.rpt_err_cnt = err_q;
endmodule

// File: doc/axrm_error_monitor.md
AXRM_ERROR_MONITOR -- requirements
Module: axrm_error_monitor

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 8, meaning log2 of the number of samples per report window (legal range 1..12).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-004 SHALL have port clear, input, 1 bit, meaning a synchronous window restart.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the sample is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample.
REQ-007 SHALL have port a, input, 8 bits, meaning the multiplicand applied to the upstream 8x8 approximate multiplier.
REQ-008 SHALL have port b, input, 8 bits, meaning the multiplier operand.
REQ-009 SHALL have port result, input, 16 bits, meaning the approximate product from the upstream 8x8 approximate multiplier.
REQ-010 SHALL have port rpt_valid, output, 1 bit, meaning the window report is valid.
REQ-011 SHALL have port rpt_ready, input, 1 bit, meaning the consumer takes the report.
REQ-012 SHALL have port rpt_sum_ed, output, 16+WIN_LOG2 bits, meaning the sum of error distances.
REQ-013 SHALL have port rpt_err_cnt, output, WIN_LOG2+1 bits, meaning the count of samples with nonzero error.
REQ-014 SHALL have port rpt_max_ed, output, 16 bits, meaning the maximum error distance in the window.

Function
REQ-015 SHALL accept a sample on every rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL compute the error distance as ED = |a*b - result|, using an exact 16-bit product and a 17-bit signed difference, giving a 16-bit magnitude.
REQ-017 SHALL register ED and a valid flag in one pipeline stage at the accept edge, and SHALL fold ED into the accumulators on the following edge.
REQ-018 SHALL implement the FSM as ACCUM -> FLUSH -> REPORT -> ACCUM.
REQ-019 SHALL drive in_ready = 1 only in ACCUM, and SHALL ignore in_valid while in FLUSH or REPORT.
REQ-020 SHALL keep a sample counter of WIN_LOG2 bits.
REQ-021 SHALL transition ACCUM to FLUSH on the edge that accepts sample number 2^WIN_LOG2, with the counter wrapping to 0.
REQ-022 SHALL transition FLUSH to REPORT after exactly one cycle, with the final ED already accumulated, so rpt_valid rises at edge E+1, where E is the final accept edge.
REQ-023 SHALL drive rpt_valid = 1 only in REPORT, and SHALL hold all rpt_* outputs stable while rpt_valid=1 and rpt_ready=0.
REQ-024 SHALL, on an edge with rpt_valid and rpt_ready both 1, zero the accumulators and return to ACCUM, so in_ready is 1 in the next cycle.
REQ-025 SHALL add ED to rpt_sum_ed without saturation, because overflow is impossible by width.
REQ-026 SHALL increment rpt_err_cnt only when ED is nonzero.
REQ-027 SHALL update rpt_max_ed when ED is greater than the current rpt_max_ed.
REQ-028 SHALL give clear priority over all other events: when clear=1 at an edge, zero the accumulators, the counter and the pipeline valid flag, drop any sample offered that cycle, and go to ACCUM, including from REPORT.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state=ACCUM, counter=0, pipeline valid=0, rpt_valid=0, rpt_sum_ed=0, rpt_err_cnt=0 and rpt_max_ed=0.
REQ-030 SHALL drive in_ready=1 during and after reset.
REQ-031 SHALL discard any partial window or pending report when reset is asserted mid-operation.

Configuration
REQ-032 SHALL, when macro AXRM_ERROR_MONITOR_MAX_ED_EN is defined, implement the max-ED tracker as described in REQ-027.
REQ-033 SHALL, when AXRM_ERROR_MONITOR_MAX_ED_EN is undefined, drive rpt_max_ed as constant 0, build no comparator or register for it, and leave all other behaviour identical.

Verification
REQ-034 SHALL cover reset: rst_n low mid-cycle -> all rpt_* = 0, rpt_valid=0 and in_ready=1 with no clock edge required.
REQ-035 SHALL cover an exact window: WIN_LOG2=2 with four exact samples (255,255,65025), (0,0,0), (16,16,256), (1,200,200) -> rpt_sum_ed=0, rpt_err_cnt=0, rpt_max_ed=0, and rpt_valid high at E+1.
REQ-036 SHALL cover a mixed window: WIN_LOG2=2 with samples (3,3,8), (10,10,90), (0,5,3), (255,255,65025) -> ED values 1, 10, 3, 0, giving rpt_sum_ed=14, rpt_err_cnt=3, rpt_max_ed=10, or rpt_max_ed=0 with the macro off.
REQ-037 SHALL cover backpressure: rpt_ready held low for 5 cycles in REPORT while in_valid=1 -> rpt_* stable, in_ready=0 and no sample counted; then rpt_ready=1 -> next cycle in_ready=1 and accumulators=0.
REQ-038 SHALL cover a mid-window clear: two erroneous samples, then clear=1 together with in_valid=1 -> that sample is dropped; a fresh four-sample window then reports only its own statistics.
REQ-039 SHALL cover worst case: WIN_LOG2=12 with 4096 samples (0,0,65535) -> rpt_sum_ed=268431360, rpt_err_cnt=4096, rpt_max_ed=65535, with no wrap.
